// File: rtl/mult_sched_pkg.sv
// mult_sched_pkg: shared constants, index-width helper and pipeline stage type
// for the round-robin multiplier scheduler (mult_sched, rr_arbiter).
package mult_sched_pkg;

   localparam int LAT_MIN    = 1;
   localparam int LAT_MAX    = 4;
   localparam int ID_MAX_W   = 4;
   localparam int PROD_MAX_W = 64;

   // Requester-index width; a single requester still needs one bit.
   function automatic int idx_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   // One multiplier pipeline stage. Fields are sized for the largest
   // supported configuration; the top slices them to its parameters.
   typedef struct packed {
      logic                  valid;
      logic [ID_MAX_W-1:0]   id;
      logic [PROD_MAX_W-1:0] product;
   } stage_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin single grant, search starts at i_ptr.
// Ports: i_req (request vector), i_ptr (start index), i_en (grant enable),
//        o_gnt (one-hot grant, zero when disabled), o_idx (winning index).
module rr_arbiter
   import mult_sched_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]        i_req,
   input  logic [idx_w(N)-1:0] i_ptr,
   input  logic                i_en,
   output logic [N-1:0]        o_gnt,
   output logic [idx_w(N)-1:0] o_idx
);

   localparam int IW = idx_w(N);

   always_comb begin : p_arb
      logic          w_found;
      int            w_j;
      logic [IW-1:0] w_sel;
      w_found = 1'b0;
      w_j     = 0;
      w_sel   = '0;
      o_gnt   = '0;
      o_idx   = '0;
      for (int k = 0; k < N; k++) begin
         // Wrap the rotated position without a modulo.
         w_j = int'(i_ptr) + k;
         if (w_j >= N) w_j = w_j - N;
         w_sel = IW'(w_j);
         if (!w_found && i_req[w_sel]) begin
            w_found      = 1'b1;
            o_gnt[w_sel] = 1'b1;
            o_idx        = w_sel;
         end
      end
      if (!i_en) o_gnt = '0;
   end

endmodule

// File: rtl/mult_sched.sv
// mult_sched: round-robin scheduler feeding a LATENCY-deep shared multiplier.
// Ports: clk, rst (async, active-high); req_valid/req_ready/req_a/req_b/
//        req_signed per requester; rsp_valid/rsp_ready/rsp_id/rsp_product.
//        Optional op_count (16-bit saturating transfer count) when the
//        macro MULT_SCHED_PERF_EN is defined.
module mult_sched
   import mult_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8,
   parameter int LATENCY = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*WIDTH-1:0]   req_a,
   input  logic [NUM_REQ*WIDTH-1:0]   req_b,
   input  logic [NUM_REQ-1:0]         req_signed,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [idx_w(NUM_REQ)-1:0]  rsp_id,
   output logic [2*WIDTH-1:0]         rsp_product
`ifdef MULT_SCHED_PERF_EN
   ,
   output logic [15:0]                op_count
`endif
);

   localparam int IW  = idx_w(NUM_REQ);
   localparam int LAT = (LATENCY < LAT_MIN) ? LAT_MIN :
                        (LATENCY > LAT_MAX) ? LAT_MAX : LATENCY;

   stage_t              r_stg [LAT];
   logic [IW-1:0]       r_ptr;

   logic                w_adv;
   logic                w_en;
   logic                w_xfer;
   logic [NUM_REQ-1:0]  w_gnt;
   logic [IW-1:0]       w_idx;
   logic [WIDTH-1:0]    w_a;
   logic [WIDTH-1:0]    w_b;
   logic                w_sgn;
   logic [2*WIDTH-1:0]  w_ea;
   logic [2*WIDTH-1:0]  w_eb;
   logic [2*WIDTH-1:0]  w_prod;
   logic                w_unused;

   // The whole pipeline freezes while the output is held.
   assign w_adv = !r_stg[LAT-1].valid || rsp_ready;
   // Reset also masks grants so req_ready reads zero during reset.
   assign w_en  = w_adv && !rst;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .i_req (req_valid),
      .i_ptr (r_ptr),
      .i_en  (w_en),
      .o_gnt (w_gnt),
      .o_idx (w_idx)
   );

   assign req_ready = w_gnt;
   assign w_xfer    = |w_gnt;

   always_comb begin
      w_a   = '0;
      w_b   = '0;
      w_sgn = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_idx == IW'(i)) begin
            w_a   = req_a[i*WIDTH +: WIDTH];
            w_b   = req_b[i*WIDTH +: WIDTH];
            w_sgn = req_signed[i];
         end
      end
   end

   // Extend to full width first so the low half of the product is exact
   // for both signed and unsigned operands.
   assign w_ea   = w_sgn ? {{WIDTH{w_a[WIDTH-1]}}, w_a} : {{WIDTH{1'b0}}, w_a};
   assign w_eb   = w_sgn ? {{WIDTH{w_b[WIDTH-1]}}, w_b} : {{WIDTH{1'b0}}, w_b};
   assign w_prod = w_ea * w_eb;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= '0;
         for (int k = 0; k < LAT; k++) r_stg[k] <= '0;
      end else if (w_adv) begin
         if (w_xfer) begin
            r_ptr <= (int'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + 1'b1;
         end
         r_stg[0].valid   <= w_xfer;
         r_stg[0].id      <= w_xfer ? ID_MAX_W'(w_idx) : '0;
         r_stg[0].product <= w_xfer ? PROD_MAX_W'(w_prod) : '0;
         for (int k = 1; k < LAT; k++) r_stg[k] <= r_stg[k-1];
      end
   end

   assign rsp_valid   = r_stg[LAT-1].valid;
   assign rsp_id      = r_stg[LAT-1].id[IW-1:0];
   assign rsp_product = r_stg[LAT-1].product[2*WIDTH-1:0];

   // Upper struct bits beyond this configuration are constant zero.
   assign w_unused = ^{r_stg[LAT-1].id, r_stg[LAT-1].product};

`ifdef MULT_SCHED_PERF_EN
   logic [15:0] r_op_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op_count <= '0;
      end else if (w_xfer && r_op_count != 16'hFFFF) begin
         r_op_count <= r_op_count + 16'd1;
      end
   end

   assign op_count = r_op_count;
`endif

endmodule

// File: tb/tb_mult_sched.sv
// tb_mult_sched: randomized and directed bench for mult_sched against a
// queue-based reference model (round-robin order, product, latency, hold).
module tb_mult_sched;

   localparam int N = 4;
   localparam int W = 8;
   localparam int L = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_a;
   logic [N*W-1:0] req_b;
   logic [N-1:0]   req_signed;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [1:0]     rsp_id;
   logic [2*W-1:0] rsp_product;
`ifdef MULT_SCHED_PERF_EN
   logic [15:0]    op_count;
`endif

   mult_sched #(.NUM_REQ(N), .WIDTH(W), .LATENCY(L)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_signed  (req_signed),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_id      (rsp_id),
      .rsp_product (rsp_product)
`ifdef MULT_SCHED_PERF_EN
      ,
      .op_count    (op_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [15:0] prod;
      int          c;
      int          s;
   } exp_t;

   exp_t        sbq[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          stall_cnt = 0;
   int          ptr_m = 0;
   int          op_cnt_m = 0;
   int          last_gnt = -1;
   logic [N-1:0] acc = '0;
   bit          prev_stall = 0;
   logic [18:0] snap = '0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] ref_mul(input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic s);
      int x;
      int y;
      x = int'(a);
      y = int'(b);
      if (s && a[7]) x = x - 256;
      if (s && b[7]) y = y - 256;
      return 16'(x * y);
   endfunction

   // One clock cycle: compare at the negedge, then step past the posedge.
   task automatic tick();
      logic         adv;
      int           win;
      int           j;
      logic [N-1:0] exp_rdy;
      exp_t         e;
      @(negedge clk);
      win     = -1;
      exp_rdy = '0;
      if (rst) begin
         check("rst_ready", req_ready, 0);
         check("rst_valid", rsp_valid, 0);
         check("rst_id", rsp_id, 0);
         check("rst_prod", rsp_product, 0);
`ifdef MULT_SCHED_PERF_EN
         check("rst_opcnt", op_count, 0);
`endif
         sbq.delete();
         ptr_m      = 0;
         op_cnt_m   = 0;
         prev_stall = 0;
      end else begin
         adv = !rsp_valid || rsp_ready;
         if (prev_stall) check("hold", {rsp_valid, rsp_id, rsp_product}, snap);
         if (adv) begin
            for (int k = 0; k < N; k++) begin
               j = (ptr_m + k) % N;
               if (win < 0 && req_valid[j]) win = j;
            end
         end
         if (win >= 0) exp_rdy[win] = 1'b1;
         check("ready", req_ready, exp_rdy);
         if (sbq.size() == 0) begin
            check("spurious", rsp_valid, 0);
         end else if (rsp_valid && rsp_ready) begin
            e = sbq.pop_front();
            check("id", rsp_id, e.id);
            check("prod", rsp_product, e.prod);
            check("latency", cyc - e.c - (stall_cnt - e.s), L);
         end
`ifdef MULT_SCHED_PERF_EN
         check("opcnt", op_count, op_cnt_m);
`endif
         if (win >= 0) begin
            e.id   = win;
            e.prod = ref_mul(req_a[win*W +: W], req_b[win*W +: W],
                             req_signed[win]);
            e.c    = cyc;
            e.s    = stall_cnt;
            sbq.push_back(e);
            ptr_m = (win + 1) % N;
            if (op_cnt_m < 65535) op_cnt_m++;
         end
         prev_stall = rsp_valid && !rsp_ready;
         if (prev_stall) begin
            stall_cnt++;
            snap = {rsp_valid, rsp_id, rsp_product};
         end
      end
      acc      = req_valid & req_ready;
      last_gnt = win;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Requesters keep valid and operands until accepted.
   task automatic reqs_update(input logic [N-1:0] en);
      for (int i = 0; i < N; i++) begin
         if (acc[i] || !req_valid[i]) begin
            req_valid[i] = en[i];
            if (en[i]) begin
               req_a[i*W +: W] = W'($urandom);
               req_b[i*W +: W] = W'($urandom);
               req_signed[i]   = 1'($urandom);
            end
         end
      end
   endtask

   task automatic run_op(input int idx, input logic [7:0] a,
                         input logic [7:0] b, input logic s,
                         input logic [15:0] p, input string tag);
      req_valid            = '0;
      req_valid[idx]       = 1'b1;
      req_a[idx*W +: W]    = a;
      req_b[idx*W +: W]    = b;
      req_signed[idx]      = s;
      tick();
      check({tag, "_acc"}, acc, N'(1 << idx));
      req_valid = '0;
      check({tag, "_v1"}, rsp_valid, 0);
      tick();
      check({tag, "_v2"}, rsp_valid, 1);
      check({tag, "_id"}, rsp_id, idx);
      check({tag, "_prod"}, rsp_product, p);
      tick();
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      rsp_ready = 1'b1;
      while ((sbq.size() != 0 || req_valid != '0) && n < 60) begin
         tick();
         reqs_update('0);
         n++;
      end
      check(tag, sbq.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      rst        = 1'b1;
      req_valid  = '1;
      req_a      = '0;
      req_b      = '0;
      req_signed = '0;
      rsp_ready  = 1'b1;
      repeat (2) tick();
      rst       = 1'b0;
      req_valid = '0;
      tick();

      run_op(0, 8'hFF, 8'hFF, 1'b0, 16'hFE01, "ffff_u");
      run_op(2, 8'hFF, 8'h02, 1'b1, 16'hFFFE, "ff02_s");
      run_op(2, 8'hFF, 8'h02, 1'b0, 16'h01FE, "ff02_u");

      rst = 1'b1;
      tick();
      rst = 1'b0;
      reqs_update('1);
      for (int k = 0; k < 6; k++) begin
         tick();
         check("rr_order", last_gnt, k % N);
         reqs_update('1);
      end

      rsp_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         reqs_update('1);
      end
      rsp_ready = 1'b1;
      drain("drain_stall");

      reqs_update('1);
      tick();
      reqs_update('1);
      tick();
      rst = 1'b1;
      #1;
      check("rst_imm_valid", rsp_valid, 0);
      check("rst_imm_ready", req_ready, 0);
      tick();
      rst       = 1'b0;
      req_valid = '0;
      acc       = '0;
      repeat (4) tick();
      reqs_update('1);
      tick();
      check("gnt_after_rst", last_gnt, 0);
      drain("drain_rst");

`ifdef MULT_SCHED_PERF_EN
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req_valid = '0;
      acc       = '0;
      for (int k = 0; k < 10; k++) begin
         reqs_update('1);
         tick();
      end
      req_valid = '0;
      tick();
      check("opcnt10", op_count, 10);
      rst = 1'b1;
      #1;
      check("opcnt_rst", op_count, 0);
      tick();
      rst = 1'b0;
      acc = '0;
      drain("drain_perf");
`endif

      for (int k = 0; k < 400; k++) begin
         rsp_ready = ($urandom_range(0, 9) < 7);
         reqs_update(N'($urandom));
         tick();
      end
      drain("drain_final");
      tick();
      check("idle_valid", rsp_valid, 0);
      check("idle_ready", req_ready, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_sched.md
MULT_SCHED -- requirements
Module: mult_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of requester ports (2..16).
REQ-002 SHALL have parameter WIDTH, default 8, meaning operand width in bits.
REQ-003 SHALL have parameter LATENCY, default 2, meaning multiplier pipeline depth in cycles (1..4).
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  meaning reset, asynchronous and active-high.
REQ-006 SHALL have port req_valid  input  NUM_REQ  meaning requester i offers an operation.
REQ-007 SHALL have port req_ready  output  NUM_REQ  meaning requester i's operation is accepted this cycle.
REQ-008 SHALL have port req_a  input  NUM_REQ*WIDTH  meaning operand A, slice i belongs to requester i.
REQ-009 SHALL have port req_b  input  NUM_REQ*WIDTH  meaning operand B, slice i belongs to requester i.
REQ-010 SHALL have port req_signed  input  NUM_REQ  meaning 1 = signed, 0 = unsigned multiply for requester i.
REQ-011 SHALL have port rsp_valid  output  1  meaning a result is presented.
REQ-012 SHALL have port rsp_ready  input  1  meaning the consumer takes the result.
REQ-013 SHALL have port rsp_id  output  clog2(NUM_REQ)  meaning index of the requester that issued the result.
REQ-014 SHALL have port rsp_product  output  2*WIDTH  meaning the product.

Function
REQ-015 SHALL define advance = !rsp_valid || rsp_ready; the whole pipeline moves only when advance=1, otherwise all stages hold.
REQ-016 SHALL grant at most one requester per cycle, round-robin: search starts at pointer ptr, first asserted req_valid wins.
REQ-017 SHALL drive req_ready[i] combinationally = grant[i] && advance; a transfer happens when req_valid[i] && req_ready[i].
REQ-018 SHALL set ptr to (granted index + 1) mod NUM_REQ after each transfer; ptr is unchanged when there is no transfer.
REQ-019 SHALL NOT let req_ready depend on the operand inputs; requesters hold valid and operands until accepted.
REQ-020 SHALL compute the product on operands sign-extended to 2*WIDTH when req_signed=1 and zero-extended when it is 0; the result is the low 2*WIDTH bits.
REQ-021 SHALL present a transfer at cycle t as rsp_valid at t+LATENCY when there are no stalls, with rsp_id and product carried alongside in the pipeline.
REQ-022 SHALL sustain one accept per cycle while rsp_ready=1, with back-to-back results and no bubbles.
REQ-023 SHALL hold rsp_valid, rsp_id and rsp_product stable while rsp_valid=1 and rsp_ready=0.
REQ-024 SHALL allow a consume and a new accept in the same cycle.
REQ-025 SHALL keep req_ready all zero, ptr unchanged and rsp_valid=0 once the pipeline drains, when no requester is valid; bubbles propagate as invalid stages.

Reset
REQ-026 SHALL, while rst=1, clear all stage valid bits, set ptr=0, and drive rsp_valid=0, rsp_id=0, rsp_product=0, req_ready=0.
REQ-027 SHALL discard in-flight operations on reset mid-operation; no stale result appears after rst deasserts.

Configuration
REQ-028 SHALL, with macro MULT_SCHED_PERF_EN defined, add output op_count (16 bits): counts transfers, saturates at 16'hFFFF, and resets to 0.
REQ-029 SHALL, without MULT_SCHED_PERF_EN, omit the op_count port and counter, with otherwise identical behaviour.

Structure
REQ-030 SHALL place in package mult_sched_pkg: the requester-index width function, LATENCY bounds constants, and a stage struct typedef {valid, id, product}.
REQ-031 SHALL implement arbitration in sub-module rr_arbiter (inputs: request vector, ptr, enable; outputs: one-hot grant, granted index).

Verification (NUM_REQ=4, WIDTH=8, LATENCY=2)
REQ-032 SHALL check: after reset, req0 valid, a=8'hFF, b=8'hFF, unsigned -> accepted at t, rsp_valid at t+2, product 16'hFE01, id 0.
REQ-033 SHALL check: req2 a=8'hFF, b=8'h02, signed -> product 16'hFFFE, id 2; same operands unsigned -> 16'h01FE.
REQ-034 SHALL check: all four valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1, one per cycle, ids in the same order.
REQ-035 SHALL check: rsp_ready=0 for 5 cycles with a full pipeline -> outputs stable, req_ready=0, and all results delivered in order afterwards with none lost.
REQ-036 SHALL check: rst pulsed with two operations in flight -> rsp_valid=0 immediately, no result after release, next grant goes to requester 0.
REQ-037 SHALL check, with MULT_SCHED_PERF_EN: 10 transfers -> op_count=10; reset -> 0.
